accel_filter: RTL and testbench

ACCEL_FILTER -- requirements
Module: accel_filter

---
 rtl/accel_pkg.sv | 6 +
 rtl/accel_sample_ring.sv | 40 ++++
 rtl/accel_filter.sv | 101 ++++++++++
 tb/tb_accel_filter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared widths and FSM encoding for the accelerometer path
package accel_pkg;
  localparam int ACC_DATA_W = 16;
  localparam int ACC_LOG2_DEPTH = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUTPUT} state_t;
endpackage

// File: rtl/accel_sample_ring.sv
// accel_sample_ring: per-axis sample ring with write pointer, oldest-slot read and clear
// ports: clk, reset (async low), clr (sync), we, y_new/z_new in; y_old/z_old (slot at ptr), ptr out
module accel_sample_ring #(
  parameter int DATA_W = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     we,
  input  logic signed [DATA_W-1:0] y_new,
  input  logic signed [DATA_W-1:0] z_new,
  output logic signed [DATA_W-1:0] y_old,
  output logic signed [DATA_W-1:0] z_old,
  output logic [LOG2_DEPTH-1:0]    ptr
);
  logic signed [DATA_W-1:0] y_mem [2**LOG2_DEPTH];
  logic signed [DATA_W-1:0] z_mem [2**LOG2_DEPTH];
  assign y_old = y_mem[ptr];
  assign z_old = z_mem[ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int i = 0; i < 2**LOG2_DEPTH; i++) begin
        y_mem[i] <= '0;
        z_mem[i] <= '0;
      end
    end else if (clr) begin
      ptr <= '0;
      for (int i = 0; i < 2**LOG2_DEPTH; i++) begin
        y_mem[i] <= '0;
        z_mem[i] <= '0;
      end
    end else if (we) begin
      y_mem[ptr] <= y_new;
      z_mem[ptr] <= z_new;
      ptr <= ptr + LOG2_DEPTH'(1);
    end
  end
endmodule

// File: rtl/accel_filter.sv
// accel_filter: moving average of Y/Z samples with tilt detection and overrun flag
// ports: clk, reset (async low), sample_valid/y_in/z_in, flush (sync clear) in;
//        y_avg/z_avg/avg_valid, busy, window_full, overrun (sticky), tilt_right/tilt_left out
module accel_filter
  import accel_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int LOG2_DEPTH = ACC_LOG2_DEPTH,
  parameter int TILT_TH = 200,
  parameter int HYST = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] z_in,
  input  logic                     flush,
  output logic signed [DATA_W-1:0] y_avg,
  output logic signed [DATA_W-1:0] z_avg,
  output logic                     avg_valid,
  output logic                     busy,
  output logic                     window_full,
  output logic                     overrun,
  output logic                     tilt_right,
  output logic                     tilt_left
);
  localparam int SW = DATA_W + LOG2_DEPTH;
  localparam logic signed [DATA_W-1:0] SET_HI = DATA_W'(TILT_TH);
  localparam logic signed [DATA_W-1:0] REL_HI = DATA_W'(TILT_TH - HYST);
  localparam logic signed [DATA_W-1:0] SET_LO = DATA_W'(-TILT_TH);
  localparam logic signed [DATA_W-1:0] REL_LO = DATA_W'(HYST - TILT_TH);
  state_t state;
  logic signed [DATA_W-1:0] y_reg, z_reg, y_old, z_old;
  logic signed [SW-1:0] y_sum, z_sum;
  logic [LOG2_DEPTH-1:0] ptr;
  logic we;
  assign we = state == ST_ACCUM && !flush;
  assign busy = state != ST_IDLE;
  accel_sample_ring #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
    .clk(clk), .reset(reset), .clr(flush), .we(we),
    .y_new(y_reg), .z_new(z_reg), .y_old(y_old), .z_old(z_old), .ptr(ptr)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      y_reg <= '0;
      z_reg <= '0;
      y_sum <= '0;
      z_sum <= '0;
      y_avg <= '0;
      z_avg <= '0;
      avg_valid <= 1'b0;
      window_full <= 1'b0;
      overrun <= 1'b0;
      tilt_right <= 1'b0;
      tilt_left <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      y_reg <= '0;
      z_reg <= '0;
      y_sum <= '0;
      z_sum <= '0;
      y_avg <= '0;
      z_avg <= '0;
      avg_valid <= 1'b0;
      window_full <= 1'b0;
      overrun <= 1'b0;
      tilt_right <= 1'b0;
      tilt_left <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      // tilt follows the average published on the previous cycle
      if (avg_valid) begin
        tilt_right <= y_avg > SET_HI ? 1'b1 : y_avg < REL_HI ? 1'b0 : tilt_right;
        tilt_left <= y_avg < SET_LO ? 1'b1 : y_avg > REL_LO ? 1'b0 : tilt_left;
      end
      if (sample_valid && state != ST_IDLE) overrun <= 1'b1;
      unique case (state)
        ST_IDLE: if (sample_valid) begin
          y_reg <= y_in;
          z_reg <= z_in;
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          y_sum <= y_sum - SW'(y_old) + SW'(y_reg);
          z_sum <= z_sum - SW'(z_old) + SW'(z_reg);
          state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          y_avg <= DATA_W'(y_sum >>> LOG2_DEPTH);
          z_avg <= DATA_W'(z_sum >>> LOG2_DEPTH);
          avg_valid <= 1'b1;
          // pointer back at slot 0 means a full window has been written
          window_full <= window_full | (ptr == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_filter.sv
// tb_accel_filter: directed and random checks of accel_filter against a window-average model
module tb_accel_filter;
  logic clk = 1'b0, reset = 1'b0, sample_valid = 1'b0, flush = 1'b0;
  logic signed [15:0] y_in = '0, z_in = '0, y_avg, z_avg;
  logic avg_valid, busy, window_full, overrun, tilt_right, tilt_left;
  int n_cmp = 0, n_bad = 0;
  int qy[$], qz[$];
  int m_cnt = 0, m_y = 0, m_z = 0, m_tr = 0, m_tl = 0, m_ov = 0;

  accel_filter dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .y_in(y_in), .z_in(z_in),
    .flush(flush), .y_avg(y_avg), .z_avg(z_avg), .avg_valid(avg_valid), .busy(busy),
    .window_full(window_full), .overrun(overrun), .tilt_right(tilt_right), .tilt_left(tilt_left)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor8(input int s);
    int m;
    m = ((s % 8) + 8) % 8;
    return (s - m) / 8;
  endfunction

  task automatic m_clear();
    qy.delete();
    qz.delete();
    m_cnt = 0; m_y = 0; m_z = 0; m_tr = 0; m_tl = 0; m_ov = 0;
  endtask

  // average over the last eight accepted samples, missing ones counting as zero
  task automatic m_push(input int y, input int z);
    int sy, sz;
    qy.push_back(y);
    qz.push_back(z);
    if (qy.size() > 8) begin
      void'(qy.pop_front());
      void'(qz.pop_front());
    end
    sy = 0; sz = 0;
    foreach (qy[i]) begin
      sy += qy[i];
      sz += qz[i];
    end
    m_cnt++;
    m_y = floor8(sy);
    m_z = floor8(sz);
    m_tr = m_y > 200 ? 1 : m_y < 168 ? 0 : m_tr;
    m_tl = m_y < -200 ? 1 : m_y > -168 ? 0 : m_tl;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_yavg"}, y_avg, 0);
    check({tag, "_zavg"}, z_avg, 0);
    check({tag, "_avalid"}, avg_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_full"}, window_full, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_tr"}, tilt_right, 0);
    check({tag, "_tl"}, tilt_left, 0);
  endtask

  task automatic check_out();
    check("avg_valid", avg_valid, 1);
    check("y_avg", y_avg, m_y);
    check("z_avg", z_avg, m_z);
    check("window_full", window_full, m_cnt >= 8);
    check("overrun", overrun, m_ov);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_tilt();
    tick();
    check("avg_valid_drop", avg_valid, 0);
    check("tilt_right", tilt_right, m_tr);
    check("tilt_left", tilt_left, m_tl);
  endtask

  // drive one sample; with dup set, a second strobe follows while busy
  task automatic send(input int y, input int z, input bit dup = 0);
    sample_valid = 1'b1; y_in = 16'(y); z_in = 16'(z);
    tick();
    if (dup) begin
      y_in = 16'(y + 1000); z_in = 16'(z + 1000);
      m_ov = 1;
    end else sample_valid = 1'b0;
    check("busy_accum", busy, 1);
    check("avg_valid_early", avg_valid, 0);
    check("tilt_right_prev", tilt_right, m_tr);
    check("tilt_left_prev", tilt_left, m_tl);
    tick();
    sample_valid = 1'b0;
    check("avg_valid_mid", avg_valid, 0);
    tick();
    m_push(y, z);
    check_out();
  endtask

  task automatic do_flush();
    flush = 1'b1; sample_valid = 1'b1; y_in = 16'(123);
    tick();
    flush = 1'b0; sample_valid = 1'b0;
    m_clear();
    check_zero("flush");
    tick();
    check("flush_ignored_busy", busy, 0);
  endtask

  initial begin
    tick(); tick();
    check_zero("reset");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) send(80, -16);
    check_tilt();
    do_flush();
    for (int i = 0; i < 8; i++) send(300, 5);
    for (int i = 0; i < 8; i++) send(180, 5);
    check_tilt();
    check("tilt_hold_180", tilt_right, 1);
    for (int i = 0; i < 8; i++) send(100, 5);
    check_tilt();
    check("tilt_released", tilt_right, 0);
    send(7, 9, 1);
    tick();
    check("overrun_single_pulse", avg_valid, 0);
    check("overrun_sticky", overrun, 1);
    do_flush();
    for (int i = 0; i < 8; i++) send(-1, 3);
    check("floor_neg1", y_avg, -1);
    for (int i = 0; i < 8; i++) send(-32768, 32767);
    check_tilt();
    check("tilt_left_min", tilt_left, 1);
    sample_valid = 1'b1; y_in = 16'(500);
    tick();
    sample_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    m_clear();
    check_zero("flush_accum");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_accum_noavg", avg_valid, 0);
    end
    send(8, -8);
    check("after_flush_y", y_avg, 1);
    check_tilt();
    sample_valid = 1'b1; y_in = 16'(640);
    tick();
    sample_valid = 1'b0;
    tick();
    #1 reset = 1'b0;
    #1;
    m_clear();
    check_zero("async_reset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_noavg", avg_valid, 0);
    end
    send(16, 24);
    check_tilt();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      if (i % 2 == 0) send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 7) == 0);
      else send(int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400);
    end
    check_tilt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
